// File: rtl/call_stack.sv
// call_stack: parametrised LIFO frame stack with full/empty/count status, replace, pop-and-read
// and sticky overflow/underflow flags. Define CALL_STACK_PEEK2_EN to add the dout2 second-from-top read.
module call_stack #(
   parameter int VAL_W  = 128,
   parameter int N_W    = 5,
   parameter int FLAG_W = 2,
   parameter int DEPTH  = 32,
   localparam int FRAME_W = FLAG_W + N_W + VAL_W,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] din,
   input  logic               push,
   input  logic               pop,
   input  logic               top,
   input  logic               clr_err,
   output logic [FRAME_W-1:0] dout,
`ifdef CALL_STACK_PEEK2_EN
   output logic [FRAME_W-1:0] dout2,
`endif
   output logic [CNT_W-1:0]   count,
   output logic               empty,
   output logic               full,
   output logic               ovf_err,
   output logic               unf_err
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [FRAME_W-1:0] mem [DEPTH];
   logic               is_empty;
   logic               is_full;
   logic [ADDR_W-1:0]  top_idx;
   logic [ADDR_W-1:0]  wr_idx;
   logic               wr_en;
   logic               inc;
   logic               dec;
   logic               ovf_set;
   logic               unf_set;

   assign is_empty = (count == '0);
   assign is_full  = (count == CNT_W'(DEPTH));
   assign empty    = is_empty;
   assign full     = is_full;
   assign top_idx  = ADDR_W'(count - CNT_W'(1));

   // Replace overwrites the current top; a push+pop on empty degrades to a plain push into slot 0.
   assign wr_idx  = (pop && !is_empty) ? top_idx : ADDR_W'(count);
   assign wr_en   = push && (pop || !is_full);
   assign inc     = push && (pop ? is_empty : !is_full);
   assign dec     = pop && !push && !is_empty;
   assign ovf_set = push && !pop && is_full;
   assign unf_set = (pop || top) && is_empty;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         dout    <= '0;
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (inc) begin
            count <= count + CNT_W'(1);
         end else if (dec) begin
            count <= count - CNT_W'(1);
         end
         if (top) begin
            dout <= is_empty ? '0 : mem[top_idx];
         end
         ovf_err <= (ovf_err && !clr_err) || ovf_set;
         unf_err <= (unf_err && !clr_err) || unf_set;
      end
   end

`ifdef CALL_STACK_PEEK2_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout2 <= '0;
      end else if (top) begin
         dout2 <= (count >= CNT_W'(2)) ? mem[ADDR_W'(count - CNT_W'(2))] : '0;
      end
   end
`endif

endmodule
